// File: rtl/addr_unit_pkg.sv
// Shared types and constants for the address unit: sequencer states,
// default register indices and lane-index sizing.
package addr_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int PC_IDX    = 0;
  localparam int SP_IDX    = 1;
  localparam int LR_IDX    = 2;
  localparam int TXA_IDX   = 3;
  localparam int ACALC_IDX = 4;

  // A single-lane register still needs a 1-bit lane port.
  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/addr_reg.sv
// One address register: whole load beats lane load beats signed step.
module addr_reg #(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 8,
  parameter int                LANES   = ADDR_W / DATA_W,
  parameter int                LANE_W  = 1,
  parameter logic [ADDR_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              bload,
  input  logic [LANE_W-1:0] lane,
  input  logic [DATA_W-1:0] lane_val,
  input  logic signed [2:0] step,
  output logic [ADDR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (bload) begin
      if (int'(lane) < LANES) q[lane*DATA_W +: DATA_W] <= lane_val;
    end else begin
      // Sign-extended step gives modular +/- wrap for free.
      q <= q + ADDR_W'(step);
    end
  end

endmodule

// File: rtl/addr_unit.sv
// Address register bank with bus muxes and a wait-state memory access
// sequencer that can post-increment the register that supplied the address.
module addr_unit
  import addr_unit_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter int                NREGS     = 6,
  parameter int                SEL_W     = $clog2(NREGS),
  parameter int                LANES     = ADDR_W / DATA_W,
  parameter int                WAIT      = 0,
  parameter int                PC_IDX    = 0,
  parameter int                SP_IDX    = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] SP_RESET  = '1,
  localparam int               LANE_W    = lane_w(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aout_en,
  input  logic [SEL_W-1:0]  aout_sel,
  input  logic              aload_en,
  input  logic [SEL_W-1:0]  aload_sel,
  input  logic [ADDR_W-1:0] abus_in,
  output logic [ADDR_W-1:0] abus_out,
  output logic              abus_oe,
  input  logic              bload_en,
  input  logic              bout_en,
  input  logic [SEL_W-1:0]  b_sel,
  input  logic [LANE_W-1:0] b_lane,
  input  logic [DATA_W-1:0] mbus_in,
  output logic [DATA_W-1:0] mbus_out,
  output logic              mbus_oe,
  input  logic              inc_en,
  input  logic              dec_en,
  input  logic [SEL_W-1:0]  step_sel,
  input  logic              acc_start,
  input  logic              acc_we,
  input  logic [SEL_W-1:0]  acc_sel,
  input  logic              acc_autoinc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);

  state_t                         state, state_nx;
  logic [3:0]                     cnt;
  logic [SEL_W-1:0]               acc_sel_q;
  logic                           auto_q, we_q, auto_fire;
  logic [NREGS-1:0][ADDR_W-1:0]   regs;
  logic [ADDR_W-1:0]              a_rd, b_rd, acc_rd;

  assign auto_fire = (state == ACCESS) && (cnt == 4'd0) && auto_q;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    localparam logic [ADDR_W-1:0] RV = (i == PC_IDX) ? RESET_VEC :
                                       (i == SP_IDX) ? SP_RESET  : '0;
    logic              hit_inc, hit_dec, hit_auto;
    logic signed [2:0] step;

    assign hit_inc  = inc_en && (step_sel == SEL_W'(i));
    assign hit_dec  = dec_en && (step_sel == SEL_W'(i));
    assign hit_auto = auto_fire && (acc_sel_q == SEL_W'(i));
    // Auto-increment is just another +1 request, so the sum covers +2 and hold.
    assign step = $signed({2'b00, hit_inc}) + $signed({2'b00, hit_auto})
                - $signed({2'b00, hit_dec});

    addr_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .RST_VAL(RV)
    ) u_reg (
      .clk     (clk),
      .rst     (rst),
      .load    (aload_en && (aload_sel == SEL_W'(i))),
      .load_val(abus_in),
      .bload   (bload_en && (b_sel == SEL_W'(i))),
      .lane    (b_lane),
      .lane_val(mbus_in),
      .step    (step),
      .q       (regs[i])
    );
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    a_rd   = '0;
    b_rd   = '0;
    acc_rd = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (aout_sel == SEL_W'(i)) a_rd   = regs[i];
      if (b_sel    == SEL_W'(i)) b_rd   = regs[i];
      if (acc_sel  == SEL_W'(i)) acc_rd = regs[i];
    end
  end

  assign abus_oe  = aout_en;
  assign abus_out = aout_en ? a_rd : '0;
  assign mbus_oe  = bout_en;
  assign mbus_out = (bout_en && (int'(b_lane) < LANES)) ? b_rd[b_lane*DATA_W +: DATA_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc_start) state_nx = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_cs = (state == ACCESS);
    mem_we = (state == ACCESS) && we_q;
    busy   = (state != IDLE);
    done   = (state == DONE);
  end

  // Access context is captured once so mid-access reloads cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      we_q      <= 1'b0;
      acc_sel_q <= '0;
      auto_q    <= 1'b0;
      cnt       <= 4'd0;
    end else if (state == IDLE && acc_start) begin
      mem_addr  <= acc_rd;
      we_q      <= acc_we;
      acc_sel_q <= acc_sel;
      auto_q    <= acc_autoinc;
      cnt       <= 4'(WAIT);
    end else if (state == ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_addr_unit.sv
// Randomised scoreboard bench for addr_unit (WAIT=2) against a cycle-level
// behavioural model of the register bank and access timing.
module tb_addr_unit;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst, aout_en, aload_en, bload_en, bout_en, inc_en, dec_en;
  logic        acc_start, acc_we, acc_autoinc;
  logic [2:0]  aout_sel, aload_sel, b_sel, step_sel, acc_sel;
  logic [0:0]  b_lane;
  logic [15:0] abus_in, abus_out, mem_addr;
  logic [7:0]  mbus_in, mbus_out;
  logic        abus_oe, mbus_oe, mem_cs, mem_we, busy, done;

  addr_unit #(.WAIT(WAIT)) dut (
    .clk(clk), .rst(rst), .aout_en(aout_en), .aout_sel(aout_sel),
    .aload_en(aload_en), .aload_sel(aload_sel), .abus_in(abus_in),
    .abus_out(abus_out), .abus_oe(abus_oe), .bload_en(bload_en),
    .bout_en(bout_en), .b_sel(b_sel), .b_lane(b_lane), .mbus_in(mbus_in),
    .mbus_out(mbus_out), .mbus_oe(mbus_oe), .inc_en(inc_en), .dec_en(dec_en),
    .step_sel(step_sel), .acc_start(acc_start), .acc_we(acc_we),
    .acc_sel(acc_sel), .acc_autoinc(acc_autoinc), .mem_addr(mem_addr),
    .mem_cs(mem_cs), .mem_we(mem_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic we; } acc_t;
  acc_t        accq[$];
  logic [15:0] aq[$];
  logic [7:0]  mq[$];

  logic [15:0] m_reg[6];
  int          m_rem = 0;
  bit          m_done = 0, m_auto = 0;
  logic [2:0]  m_sel = '0;
  bit          cur_cs = 0, cur_done = 0, mon_on = 0, prev_cs = 0;
  int          cs_run = 0;
  int          checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rd(input logic [2:0] s);
    return (s < 3'd6) ? m_reg[s] : 16'h0;
  endfunction

  task automatic idle();
    rst = 0; aout_en = 0; aload_en = 0; bload_en = 0; bout_en = 0;
    inc_en = 0; dec_en = 0; acc_start = 0; acc_we = 0; acc_autoinc = 0;
    aout_sel = 0; aload_sel = 0; b_sel = 0; step_sel = 0; acc_sel = 0;
    b_lane = 0; abus_in = 0; mbus_in = 0;
  endtask

  // Records expectations for the current cycle, advances the model, then clocks.
  task automatic tick();
    logic [15:0] nx[6];
    int          stp[6];
    bit          ld[6];
    cur_cs   = (m_rem > 0);
    cur_done = m_done;
    if (aout_en) aq.push_back(rd(aout_sel));
    if (bout_en) mq.push_back(8'(rd(b_sel) >> (8 * b_lane)));
    nx = m_reg;
    if (rst) begin
      foreach (nx[i]) nx[i] = 16'h0;
      nx[1] = 16'hFFFF;
      m_rem = 0; m_done = 0;
    end else begin
      foreach (stp[i]) begin stp[i] = 0; ld[i] = 0; end
      if (aload_en && aload_sel < 3'd6) begin nx[aload_sel] = abus_in; ld[aload_sel] = 1; end
      if (bload_en && b_sel < 3'd6 && !ld[b_sel]) begin
        nx[b_sel][8*b_lane +: 8] = mbus_in; ld[b_sel] = 1;
      end
      if (inc_en && step_sel < 3'd6) stp[step_sel]++;
      if (dec_en && step_sel < 3'd6) stp[step_sel]--;
      if (m_rem == 1 && m_auto && m_sel < 3'd6) stp[m_sel]++;
      foreach (nx[i]) if (!ld[i]) nx[i] = m_reg[i] + 16'(stp[i]);
      if (m_done) m_done = 0;
      else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end else if (acc_start) begin
        m_rem = WAIT + 1; m_sel = acc_sel; m_auto = acc_autoinc;
        accq.push_back('{rd(acc_sel), acc_we});
      end
    end
    m_reg = nx;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) if (mon_on) begin
    chk("busy", busy, cur_cs || cur_done);
    chk("mem_cs", mem_cs, cur_cs);
    chk("done", done, cur_done);
    chk("abus_oe", abus_oe, aout_en);
    chk("mbus_oe", mbus_oe, bout_en);
    if (aout_en) begin
      if (aq.size() == 0) chk("abus_q_empty", 1, 0);
      else chk("abus_out", abus_out, aq.pop_front());
    end else chk("abus_out_idle", abus_out, 0);
    if (bout_en) begin
      if (mq.size() == 0) chk("mbus_q_empty", 1, 0);
      else chk("mbus_out", mbus_out, mq.pop_front());
    end else chk("mbus_out_idle", mbus_out, 0);
    if (mem_cs || done) begin
      if (accq.size() == 0) chk("acc_q_empty", 1, 0);
      else begin
        chk("mem_addr", mem_addr, accq[0].addr);
        chk("mem_we", mem_we, mem_cs ? accq[0].we : 1'b0);
      end
    end else chk("mem_we_idle", mem_we, 0);
    if (mem_cs) cs_run++;
    else if (done) begin
      chk("cs_len", cs_run, WAIT + 1);
      cs_run = 0;
      if (accq.size() > 0) void'(accq.pop_front());
    end else begin
      // Access ended without done: reset abort, already checked against the model.
      if (prev_cs && accq.size() > 0) void'(accq.pop_front());
      cs_run = 0;
    end
    prev_cs = mem_cs;
  end

  task automatic read_all();
    for (int s = 0; s < 8; s++) begin
      idle(); aout_en = 1; aout_sel = 3'(s); tick();
    end
    idle();
  endtask

  task automatic start_pc(input logic [15:0] v);
    idle(); aload_en = 1; aload_sel = 0; abus_in = v; tick();
    idle(); acc_start = 1; acc_sel = 0; acc_autoinc = 1; tick();
    idle();
  endtask

  initial begin
    idle(); rst = 1; acc_start = 1;
    tick();
    mon_on = 1;
    tick();
    idle();
    chk("mem_addr_reset", mem_addr, 16'h0);
    read_all();

    // Wrap and hold
    idle(); aload_en = 1; aload_sel = 0; abus_in = 16'hFFFF; tick();
    idle(); inc_en = 1; step_sel = 0; tick();
    idle(); aload_en = 1; aload_sel = 1; abus_in = 16'h0; tick();
    idle(); dec_en = 1; step_sel = 1; tick();
    idle(); aload_en = 1; aload_sel = 2; abus_in = 16'h5A5A; tick();
    idle(); inc_en = 1; dec_en = 1; step_sel = 2; tick();
    read_all();

    // Byte assembly
    idle(); bload_en = 1; b_sel = 3; b_lane = 0; mbus_in = 8'h34; tick();
    idle(); bload_en = 1; b_sel = 3; b_lane = 1; mbus_in = 8'h12; tick();
    idle(); aout_en = 1; aout_sel = 3; bout_en = 1; b_sel = 3; b_lane = 1; tick();

    // Access with autoinc, plus a start while busy
    start_pc(16'h0100);
    acc_start = 1; acc_sel = 1; tick();
    idle(); repeat (5) tick();
    read_all();

    // Load beats auto-increment on the completion edge
    start_pc(16'h0300);
    tick(); tick();
    aload_en = 1; aload_sel = 0; abus_in = 16'h2000; tick();
    idle(); repeat (2) tick();
    // inc_en plus auto-increment on the completion edge
    start_pc(16'h0400);
    tick(); tick();
    inc_en = 1; step_sel = 0; tick();
    idle(); repeat (2) tick();
    read_all();

    // Abort in the second access cycle
    start_pc(16'h0500);
    tick();
    rst = 1; tick();
    idle(); repeat (3) tick();
    read_all();

    for (int n = 0; n < 1500; n++) begin
      idle();
      rst         = ($urandom_range(0, 99) == 0);
      aout_en     = $urandom_range(0, 1);
      aout_sel    = 3'($urandom_range(0, 7));
      aload_en    = ($urandom_range(0, 3) == 0);
      aload_sel   = 3'($urandom_range(0, 7));
      abus_in     = 16'($urandom);
      bload_en    = ($urandom_range(0, 3) == 0);
      bout_en     = $urandom_range(0, 1);
      b_sel       = 3'($urandom_range(0, 7));
      b_lane      = 1'($urandom_range(0, 1));
      mbus_in     = 8'($urandom);
      inc_en      = $urandom_range(0, 1);
      dec_en      = ($urandom_range(0, 2) == 0);
      step_sel    = 3'($urandom_range(0, 7));
      acc_start   = ($urandom_range(0, 3) == 0);
      acc_we      = $urandom_range(0, 1);
      acc_sel     = 3'($urandom_range(0, 7));
      acc_autoinc = $urandom_range(0, 1);
      tick();
    end
    idle(); repeat (8) tick();
    read_all();
    @(negedge clk); #1;
    chk("acc_q_drained", accq.size(), 0);
    chk("abus_q_drained", aq.size(), 0);
    chk("mbus_q_drained", mq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
